// File: rtl/fin_juego_fsm_pkg.sv
// Shared constants for the game-over controller: state encodings, counter
// width and the default game constants the HUD and start FSM agree on.
package fin_juego_fsm_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PLAY     = 3'd1;
  localparam logic [2:0] S_INVULN   = 3'd2;
  localparam logic [2:0] S_LOST     = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;

  localparam int unsigned LIVES_DEF         = 3;
  localparam int unsigned INVULN_FRAMES_DEF = 60;
  localparam int unsigned HOLD_FRAMES_DEF   = 120;

  // Lives never go below one through a decrement; the fatal hit is a
  // separate path that forces zero.
  function automatic logic [2:0] vidas_dec(input logic [2:0] v);
    return (v > 3'd1) ? (v - 3'd1) : v;
  endfunction

endpackage

// File: rtl/fin_juego_fsm_frame_contador.sv
// Frame-tick counter shared by the immunity and game-lost phases.
// Synchronous clear wins over enable; the count saturates at all-ones so a
// misconfigured terminal value can never cause a wrap-around.
module frame_contador
  import fin_juego_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Tick counter: clear, saturating increment, or hold.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (en && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign at_term = (count_r == term);

endmodule

// File: rtl/fin_juego_fsm.sv
// Game-over controller: tracks lives, post-hit immunity and invaders
// reaching the bottom, and drives the Perdio handshake back to the start FSM.
// All state lives on the falling edge of CLK; outputs come from registers.
module fin_juego_fsm
  import fin_juego_fsm_pkg::*;
#(
  parameter int unsigned LIVES         = LIVES_DEF,
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int unsigned HOLD_FRAMES   = HOLD_FRAMES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Senal_sing,
  input  logic       Tick,
  input  logic       Hit,
  input  logic       Abajo,
  output logic       Perdio,
  output logic [2:0] Vidas,
  output logic       Invulnerable
);

  localparam logic [2:0]       LIVES_C   = 3'(LIVES);
  localparam logic [CNT_W-1:0] INV_TERM  = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_FRAMES - 1);

  logic [2:0]       state_r;
  logic [2:0]       state_n_s;
  logic [2:0]       vidas_r;
  logic [2:0]       vidas_n_s;
  logic             perdio_r;
  logic             inv_r;
  logic             cnt_clr_s;
  logic             cnt_timed_s;
  logic             at_term_s;
  logic [CNT_W-1:0] term_s;

  // The counter only runs while parked in INVULN or LOST; any state change
  // restarts it from zero so each phase counts from its own entry.
  assign cnt_timed_s = (state_r == S_INVULN) || (state_r == S_LOST);
  assign cnt_clr_s   = (state_n_s != state_r) || !cnt_timed_s;
  assign term_s      = (state_r == S_LOST) ? HOLD_TERM : INV_TERM;

  frame_contador u_frame_contador (
    .clk     (CLK),
    .rst     (RST),
    .clr     (cnt_clr_s),
    .en      (Tick),
    .term    (term_s),
    .at_term (at_term_s)
  );

  // Next-state and next-lives decode; any return to IDLE reloads the lives.
  always_comb begin
    state_n_s = state_r;
    vidas_n_s = vidas_r;
    case (state_r)
      S_IDLE: begin
        vidas_n_s = LIVES_C;
        if (Senal_sing) begin
          state_n_s = S_PLAY;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_PLAY: begin
        if (!Senal_sing) begin
          state_n_s = S_IDLE;
          vidas_n_s = LIVES_C;
        end else if (Abajo) begin
          state_n_s = S_LOST;
          vidas_n_s = 3'd0;
        end else if (Hit) begin
          if (vidas_r > 3'd1) begin
            state_n_s = S_INVULN;
            vidas_n_s = vidas_dec(vidas_r);
          end else begin
            state_n_s = S_LOST;
            vidas_n_s = 3'd0;
          end
        end else begin
          state_n_s = S_PLAY;
        end
      end
      S_INVULN: begin
        if (!Senal_sing) begin
          state_n_s = S_IDLE;
          vidas_n_s = LIVES_C;
        end else if (Abajo) begin
          state_n_s = S_LOST;
          vidas_n_s = 3'd0;
        end else if (Tick && at_term_s) begin
          state_n_s = S_PLAY;
        end else begin
          state_n_s = S_INVULN;
        end
      end
      S_LOST: begin
        vidas_n_s = 3'd0;
        if (Tick && at_term_s) begin
          state_n_s = S_WAIT_REL;
        end else begin
          state_n_s = S_LOST;
        end
      end
      S_WAIT_REL: begin
        if (!Senal_sing) begin
          state_n_s = S_IDLE;
          vidas_n_s = LIVES_C;
        end else begin
          state_n_s = S_WAIT_REL;
        end
      end
      default: begin
        state_n_s = S_IDLE;
        vidas_n_s = LIVES_C;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= S_IDLE;
      vidas_r  <= LIVES_C;
      perdio_r <= 1'b0;
      inv_r    <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      vidas_r  <= vidas_n_s;
      perdio_r <= (state_n_s == S_LOST);
      inv_r    <= (state_n_s == S_INVULN);
    end
  end

  assign Perdio       = perdio_r;
  assign Vidas        = vidas_r;
  assign Invulnerable = inv_r;

endmodule

// File: tb/tb_fin_juego_fsm.sv
// Self-checking bench for fin_juego_fsm: expected outputs are queued as each
// cycle is driven and compared once the DUT has updated on the falling edge.
module tb_fin_juego_fsm;

  logic       clk;
  logic       rst;
  logic       senal_sing;
  logic       tick;
  logic       hit;
  logic       abajo;
  logic       perdio;
  logic [2:0] vidas;
  logic       invulnerable;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       p;
    logic [2:0] v;
    logic       inv;
  } exp_t;

  exp_t exp_q[$];

  fin_juego_fsm dut (
    .CLK          (clk),
    .RST          (rst),
    .Senal_sing   (senal_sing),
    .Tick         (tick),
    .Hit          (hit),
    .Abajo        (abajo),
    .Perdio       (perdio),
    .Vidas        (vidas),
    .Invulnerable (invulnerable)
  );

  // Free-running clock.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs (just after a falling edge), optionally queue the
  // expected outputs, let the DUT update on the next falling edge, compare.
  task automatic cycle(input logic s, input logic t, input logic h, input logic a,
                       input string tag, input logic p, input logic [2:0] v,
                       input logic inv, input bit chk);
    exp_t e;
    senal_sing = s;
    tick       = t;
    hit        = h;
    abajo      = a;
    if (chk) begin
      e.tag = tag; e.p = p; e.v = v; e.inv = inv;
      exp_q.push_back(e);
    end
    @(negedge clk);
    #1;
    tick = 1'b0;
    hit  = 1'b0;
    if (chk) begin
      e = exp_q.pop_front();
      chk_val({e.tag, ".perdio"}, int'(perdio), int'(e.p));
      chk_val({e.tag, ".vidas"},  int'(vidas),  int'(e.v));
      chk_val({e.tag, ".inv"},    int'(invulnerable), int'(e.inv));
    end
  endtask

  initial begin
    rst = 1'b1; senal_sing = 1'b0; tick = 1'b0; hit = 1'b0; abajo = 1'b0;
    #2;
    chk_val("rst.perdio", int'(perdio), 0);
    chk_val("rst.vidas",  int'(vidas), 3);
    chk_val("rst.inv",    int'(invulnerable), 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Start a game
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle", 1'b0, 3'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "play", 1'b0, 3'd3, 1'b0, 1'b1);

    // First hit, extra hit ignored, 60-tick immunity window
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "hit1", 1'b0, 3'd2, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "hit_immune", 1'b0, 3'd2, 1'b1, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, "inv_tick", 1'b0, 3'd2, (i < 60), 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "inv_gap", 1'b0, 3'd2, (i < 60), 1'b1);
    end

    // Hit coinciding with a Tick: that Tick must not count in INVULN
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "hit2_tick", 1'b0, 3'd1, 1'b1, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, "inv2_tick", 1'b0, 3'd1, (i < 60), 1'b1);
    end

    // Fatal hit: Perdio held for exactly 120 Ticks
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "hit3_fatal", 1'b1, 3'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 120; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1, "lost_tick", (i < 120), 3'd0, 1'b0, 1'b1);
      if (i < 120) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "lost_gap", 1'b1, 3'd0, 1'b0, 1'b1);
      end
    end

    // WAIT_REL holds while Senal_sing stays high, then reloads via IDLE
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, "wait_rel", 1'b0, 3'd0, 1'b0, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle_reload", 1'b0, 3'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "new_game", 1'b0, 3'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "new_hit", 1'b0, 3'd2, 1'b1, 1'b1);

    // Abort from INVULN, then Abajo beats a simultaneous Hit
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "abort", 1'b0, 3'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "play2", 1'b0, 3'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, "abajo_hit", 1'b1, 3'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "lost_no_inv", 1'b1, 3'd0, 1'b0, 1'b1);

    // Async reset mid-LOST at counter 50, between clock edges
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, "lost50", 1'b1, 3'd0, 1'b0, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_val("async_rst.perdio", int'(perdio), 0);
    chk_val("async_rst.vidas",  int'(vidas), 3);
    chk_val("async_rst.inv",    int'(invulnerable), 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Recovery, then Abajo during immunity overrides the window
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "after_rst", 1'b0, 3'd3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "hit_again", 1'b0, 3'd2, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, "inv_abajo", 1'b1, 3'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fin_juego_fsm.md
Name: fin_juego_fsm

Overview:
- Game-over controller; the producer end of the start/lose handshake.
- Consumes the game-enable level Senal_sing from the start FSM and tracks player lives, post-hit invulnerability and invader-reached-bottom.
- Drives Perdio back to the start FSM. Perdio is held for a fixed number of frames and then released, so the start FSM can leave its lost state and return to idle.

Parameters:
- LIVES, 3, lives loaded at game start (1..7).
- INVULN_FRAMES, 60, frame ticks of hit immunity after a non-fatal hit (1..255).
- HOLD_FRAMES, 120, frame ticks Perdio stays high (1..255).

Ports:
- CLK  input  1  system clock; all state updates on falling edge of CLK.
- RST  input  1  asynchronous reset, active-high.
- Senal_sing  input  1  game-active level from the start FSM.
- Tick  input  1  one-CLK frame pulse (vertical sync rate).
- Hit  input  1  one-CLK pulse: player ship struck by invader shot.
- Abajo  input  1  level: an invader row reached the player line.
- Perdio  output  1  game lost; high for HOLD_FRAMES frames.
- Vidas  output  3  remaining lives, for the HUD.
- Invulnerable  output  1  high during immunity window (ship blink).

Behaviour:
- Timing rules:
  - Asynchronous reset and negedge-CLK registers.
  - Outputs are registered or decoded from state only: no combinational path from inputs to outputs.
- Reset values: state IDLE, Perdio=0, Vidas=LIVES, Invulnerable=0, frame counter=0.
- States: IDLE, PLAY, INVULN, LOST, WAIT_REL.
- IDLE:
  - Vidas=LIVES and counter=0.
  - Senal_sing=1 -> PLAY on the next falling edge.
- PLAY:
  - Priority order: Senal_sing=0 first, then Abajo, then Hit.
  - Senal_sing=0 -> IDLE (abort). All other inputs are ignored that cycle.
  - Abajo=1 -> LOST, Vidas=0.
  - Hit with Vidas=1 -> LOST, Vidas=0.
  - Hit with Vidas>1 -> Vidas-1, counter=0, go to INVULN.
- INVULN:
  - Invulnerable=1. Hit is ignored.
  - Counter increments on each Tick. At counter==INVULN_FRAMES-1 with Tick -> PLAY, counter=0.
  - Abajo=1 -> LOST, Vidas=0 (overrides the counter).
  - Senal_sing=0 -> IDLE.
- LOST:
  - Perdio=1 and Vidas=0. Hit, Abajo and Senal_sing are ignored.
  - Counter cleared on entry and increments on each Tick. At counter==HOLD_FRAMES-1 with Tick -> WAIT_REL.
- WAIT_REL:
  - Perdio=0.
  - Waits for Senal_sing=0, which the start FSM produces two edges after Perdio falls; then -> IDLE, where lives reload.
  - Prevents immediate re-arm while Senal_sing is still high.
- Output decode: Perdio=1 only in LOST; Invulnerable=1 only in INVULN.
- Tick and Hit in the same cycle in PLAY: the Hit is processed. The Tick is not counted, because counting starts in INVULN.
- Counter width is 8 bits. It saturates rather than wraps if the parameters are misconfigured.
- Vidas never underflows; decrement happens only when Vidas>1.
- RST mid-game forces IDLE immediately, regardless of Tick phase.

Decomposition:
- Shared package/header:
  - State encodings (3-bit localparams S_IDLE..S_WAIT_REL).
  - Default LIVES/INVULN_FRAMES/HOLD_FRAMES, so the HUD and the start FSM agree on the constants.
- One natural sub-module: frame_contador.
  - 8-bit Tick counter with synchronous clear, enable and terminal-count compare input.
  - Shared by the INVULN and LOST phases.

Test Plan:
1. Reset, then Senal_sing=1 -> PLAY; Vidas=3, Perdio=0, Invulnerable=0.
2. Single Hit pulse in PLAY -> Vidas=2, Invulnerable=1. Extra Hit during the window leaves Vidas=2. After 60 Ticks, Invulnerable=0.
3. Three Hits, each after the immunity window -> Vidas 2,1,0. Perdio rises on the edge after the third Hit and stays high for exactly 120 Ticks.
4. Abajo=1 and Hit in the same cycle with Vidas=3 -> LOST, Vidas=0, Perdio=1. Check that no INVULN is entered.
5. After Perdio falls, hold Senal_sing=1 for 5 cycles -> stays in WAIT_REL with Perdio=0. Then Senal_sing=0 -> IDLE with Vidas=3. Then Senal_sing=1 -> new game.
6. Assert RST asynchronously mid-LOST (Perdio=1, counter=50) -> Perdio=0 and Vidas=3 without waiting for a CLK edge.
